// File: rtl/lva_access_if.sv
// lva_access_if: trigger/done handshake bus between lva_access and the lva array
interface lva_access_if #(parameter int ADDR = 10);
    logic            trigger;
    logic            write;
    logic [ADDR-1:0] addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            done;
    modport master (output trigger, write, addr, wdata, input rdata, done);
    modport slave  (input trigger, write, addr, wdata, output rdata, done);
endinterface

// File: rtl/lva_access.sv
// lva_access: sequences one load, store or increment of a local variable through the lva handshake
module lva_access #(
    parameter int  LVA_SIZE = 1024,
    parameter int  TIMEOUT  = 16,
    localparam int ADDR     = $clog2(LVA_SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [ADDR-1:0] index_i,
    input  logic [ADDR-1:0] frame_base_i,
    input  logic [7:0]      inc_const_i,
    input  logic [31:0]     stack_top_i,
    lva_access_if.master    lva,
    output logic            push_o,
    output logic [31:0]     push_value_o,
    output logic            pop_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_INC = 2'b10, OP_RSV = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      inc_q, inc_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [31:0]     rd_q, rd_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADDR:0]   sum;
    logic            bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            inc_q   <= '0;
            addr_q  <= '0;
            rd_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            inc_q   <= inc_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        inc_d   = inc_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, frame_base_i} + {1'b0, index_i};
        bad     = sum >= (ADDR+1)'(LVA_SIZE) || op_i == OP_RSV;
        unique case (state_q)
            IDLE: if (start_i) begin
                op_d    = op_i;
                inc_d   = inc_const_i;
                wdata_d = stack_top_i;
                err_d   = bad;
                addr_d  = bad ? addr_q : sum[ADDR-1:0];
                state_d = bad ? FINISH : (op_i == OP_STORE ? WR_ISSUE : RD_ISSUE);
            end
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (lva.done) begin
                    rd_d    = lva.rdata;
                    wdata_d = lva.rdata + {{24{inc_q[7]}}, inc_q};
                    state_d = op_q == OP_INC ? WR_ISSUE : FINISH;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            WR_ISSUE: begin
                cnt_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (lva.done || cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = !lva.done;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // write enable on the lva is level-sensitive, so write is confined to WR_ISSUE
    assign lva.trigger  = state_q == RD_ISSUE || state_q == WR_ISSUE;
    assign lva.write    = state_q == WR_ISSUE;
    assign lva.addr     = addr_q;
    assign lva.wdata    = wdata_q;
    assign pop_o        = state_q == WR_ISSUE && op_q == OP_STORE;
    assign push_o       = state_q == FINISH && op_q == OP_LOAD && !err_q;
    assign push_value_o = rd_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == FINISH;
    assign err_o        = state_q == FINISH && err_q;
endmodule

// File: tb/tb_lva_access.sv
// tb_lva_access: directed vectors against an lva model, checked by a done-triggered scoreboard
module tb_lva_access;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [9:0]  index, frame_base;
    logic [7:0]  inc_const;
    logic [31:0] stack_top;
    logic        push, pop, busy, done, err;
    logic [31:0] push_value;

    lva_access_if #(.ADDR(10)) lif();

    lva_access dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .index_i(index),
        .frame_base_i(frame_base), .inc_const_i(inc_const), .stack_top_i(stack_top),
        .lva(lif), .push_o(push), .push_value_o(push_value), .pop_o(pop),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];
    logic [2:0]  sh = '0;
    logic [31:0] rq = '0;
    bit          stall = 1'b0;
    bit          pre_we = 1'b0;
    logic [9:0]  pre_a;
    logic [31:0] pre_d;

    always @(posedge clk) begin
        sh <= {sh[1:0], lif.trigger};
        if (pre_we) mem[pre_a] <= pre_d;
        if (lif.trigger) begin
            if (lif.write) mem[lif.addr] <= lif.wdata;
            else rq <= mem[lif.addr];
        end
    end
    assign lif.done  = sh[2] & !stall;
    assign lif.rdata = rq;

    typedef struct {
        string       nm;
        int          lat;
        bit          err;
        bit          push;
        logic [31:0] pval;
        int          ntrig;
        logic [9:0]  addr;
        int          nwrite;
        int          wcyc;
        logic [31:0] wdata;
        int          npop;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   total_n = 0;
    int   pass_n  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total_n++;
        if (act === expv) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    function automatic exp_t mk(input string nm, input int lat, input bit e, input bit p,
                                input logic [31:0] pv, input int nt, input logic [9:0] a,
                                input int nw, input int wc, input logic [31:0] wd, input int np);
        exp_t r;
        r.nm = nm; r.lat = lat; r.err = e; r.push = p; r.pval = pv; r.ntrig = nt;
        r.addr = a; r.nwrite = nw; r.wcyc = wc; r.wdata = wd; r.npop = np; r.t0 = 0;
        return r;
    endfunction

    int          ntrig, nwrite, npop, npush, tcyc, wcyc;
    logic [9:0]  taddr;
    logic [31:0] wd, pv;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            ntrig = 0; nwrite = 0; npop = 0; npush = 0;
        end else begin
            if (lif.trigger) begin
                if (ntrig == 0) begin taddr = lif.addr; tcyc = cyc; end
                ntrig++;
            end
            if (lif.write) begin nwrite++; wd = lif.wdata; wcyc = cyc; end
            if (pop) npop++;
            if (push) begin npush++; pv = push_value; end
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk({e.nm, ".lat"}, cyc - e.t0, e.lat);
                    chk({e.nm, ".err"}, err, e.err);
                    chk({e.nm, ".push"}, npush, e.push);
                    if (e.push) chk({e.nm, ".push_value"}, pv, e.pval);
                    chk({e.nm, ".ntrig"}, ntrig, e.ntrig);
                    if (e.ntrig > 0) chk({e.nm, ".addr"}, taddr, e.addr);
                    if (e.ntrig > 0) chk({e.nm, ".trig_cyc"}, tcyc - e.t0, 1);
                    chk({e.nm, ".nwrite"}, nwrite, e.nwrite);
                    if (e.nwrite > 0) chk({e.nm, ".wcyc"}, wcyc - e.t0, e.wcyc);
                    if (e.nwrite > 0) chk({e.nm, ".wdata"}, wd, e.wdata);
                    chk({e.nm, ".npop"}, npop, e.npop);
                end
                ntrig = 0; nwrite = 0; npop = 0; npush = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        tick(1);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic [1:0] o, input logic [9:0] b, input logic [9:0] i,
                         input logic [7:0] ic, input logic [31:0] st);
        op = o; frame_base = b; index = i; inc_const = ic; stack_top = st; start = 1'b1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [9:0] b, input logic [9:0] i,
                         input logic [7:0] ic, input logic [31:0] st, input exp_t x);
        drive(o, b, i, ic, st);
        x.t0 = cyc;
        exp_q.push_back(x);
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            tick(1);
            n++;
        end
        chk("drain_in_time", 32'(n < 100), 32'd1);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".ctrl"}, {25'd0, lif.trigger, lif.write, push, pop, busy, done, err}, 32'd0);
        chk({nm, ".addr"}, lif.addr, 32'd0);
        chk({nm, ".wdata"}, lif.wdata, 32'd0);
        chk({nm, ".push_value"}, push_value, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        drive(2'b00, 10'd0, 10'd0, 8'd0, 32'd0);
        start = 1'b0;
        tick(3);
        @(negedge clk) chk_quiet("reset");
        tick(1);
        rst_n = 1'b1;
        poke(10'h013, 32'hDEADBEEF);
        poke(10'h005, 32'h00000001);
        poke(10'h3FF, 32'h0BADF00D);
        tick(1);

        issue(2'b00, 10'h010, 10'd3, 8'h00, 32'h0,
              mk("load", 5, 0, 1, 32'hDEADBEEF, 1, 10'h013, 0, 0, 32'h0, 0));
        drain();
        issue(2'b01, 10'h100, 10'h020, 8'h00, 32'h12345678,
              mk("store", 5, 0, 0, 32'h0, 1, 10'h120, 1, 1, 32'h12345678, 1));
        drain();
        chk("store.mem", mem[10'h120], 32'h12345678);
        issue(2'b10, 10'h000, 10'd5, 8'hFE, 32'h0,
              mk("inc", 9, 0, 0, 32'h0, 2, 10'h005, 1, 5, 32'hFFFFFFFF, 0));
        drain();
        chk("inc.mem", mem[10'h005], 32'hFFFFFFFF);
        issue(2'b00, 10'h3FF, 10'd1, 8'h00, 32'h0,
              mk("bounds", 1, 1, 0, 32'h0, 0, 10'h0, 0, 0, 32'h0, 0));
        drain();
        issue(2'b11, 10'h000, 10'd0, 8'h00, 32'h0,
              mk("rsv_op", 1, 1, 0, 32'h0, 0, 10'h0, 0, 0, 32'h0, 0));
        drain();
        issue(2'b00, 10'h3FE, 10'd1, 8'h00, 32'h0,
              mk("load_top", 5, 0, 1, 32'h0BADF00D, 1, 10'h3FF, 0, 0, 32'h0, 0));
        drain();

        stall = 1'b1;
        issue(2'b00, 10'h010, 10'd3, 8'h00, 32'h0,
              mk("timeout", 18, 1, 0, 32'h0, 1, 10'h013, 0, 0, 32'h0, 0));
        drain();
        stall = 1'b0;
        tick(5);

        drive(2'b01, 10'h300, 10'd0, 8'h00, 32'hAAAA5555);
        tick(1);
        start = 1'b0;
        tick(1);
        rst_n = 1'b0;
        @(negedge clk) chk("mid_busy", busy, 1'b1);
        tick(1);
        rst_n = 1'b1;
        @(negedge clk) chk_quiet("mid_reset");
        tick(6);

        issue(2'b00, 10'h010, 10'd3, 8'h00, 32'h0,
              mk("busy_ign", 5, 0, 1, 32'hDEADBEEF, 1, 10'h013, 0, 0, 32'h0, 0));
        drive(2'b01, 10'h000, 10'd9, 8'h00, 32'h55555555);
        tick(1);
        start = 1'b0;
        drain();
        tick(3);

        issue(2'b01, 10'h200, 10'd7, 8'h00, 32'hCAFEF00D,
              mk("b2b_st", 5, 0, 0, 32'h0, 1, 10'h207, 1, 1, 32'hCAFEF00D, 1));
        tick(5);
        issue(2'b00, 10'h200, 10'd7, 8'h00, 32'h0,
              mk("b2b_ld", 5, 0, 1, 32'hCAFEF00D, 1, 10'h207, 0, 0, 32'h0, 0));
        drain();
        tick(5);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
